// File: rtl/cl_pcis_rd_pkg.sv
// Shared types and constants for the PCIS read-response path.
package cl_pcis_rd_pkg;

    localparam int AR_ID_W  = 6;
    localparam int AR_LEN_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_64B    = 3'b110;

    typedef struct packed {
        logic [AR_ID_W-1:0]  id;
        logic [AR_LEN_W-1:0] len;
        logic                err;
    } ar_entry_t;

endpackage

// File: rtl/cl_pcis_ar_fifo.sv
// Small synchronous FIFO holding queued AR requests; head is visible combinationally.
module cl_pcis_ar_fifo
    import cl_pcis_rd_pkg::*;
#(
    parameter type entry_t = ar_entry_t,
    parameter int  DEPTH   = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        din,
    input  logic          pop,
    output entry_t        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cl_pcis_rd_resp.sv
// AXI4 read-response generator: queues AR requests and shapes the result stream into R bursts.
module cl_pcis_rd_resp
    import cl_pcis_rd_pkg::*;
#(
    parameter int  ID_W     = 6,
    parameter int  LEN_W    = 8,
    parameter int  DATA_W   = 512,
    parameter int  AR_DEPTH = 4,
    localparam int CW       = $clog2(AR_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   arid,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic [CW-1:0]     ar_outstanding,
    output logic              size_err
);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
        logic             err;
    } ar_req_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic             cur_err_q, cur_err_d;
    logic             size_err_q, size_err_d;

    ar_req_t          push_entry, head;
    logic             q_full, q_empty, push, pop, load, in_burst, beat_done;
    logic [CW-1:0]    q_count;

    assign push_entry = '{id: arid, len: arlen, err: (arsize != SIZE_64B)};
    assign arready    = ~q_full;
    assign push       = arvalid & ~q_full;

    cl_pcis_ar_fifo #(
        .entry_t (ar_req_t),
        .DEPTH   (AR_DEPTH)
    ) u_ar_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Stream-to-R is pure wiring in BURST so bursts run at one beat per cycle.
    assign in_burst       = (state_q == ST_BURST);
    assign beat_done      = in_burst & s_tvalid & rready;
    assign rvalid         = in_burst & s_tvalid;
    assign s_tready       = in_burst & rready;
    assign rdata          = s_tdata;
    assign rid            = cur_id_q;
    assign rlast          = in_burst & (beat_cnt_q == '0);
    assign rresp          = cur_err_q ? RESP_SLVERR : RESP_OKAY;
    assign ar_outstanding = q_count;
    assign size_err       = size_err_q;
    assign size_err_d     = size_err_q | (push & push_entry.err);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        cur_id_d   = cur_id_q;
        cur_err_d  = cur_err_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    load    = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_done) begin
                    if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    else if (!q_empty)    load       = 1'b1;
                    else                  state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reloading on the final beat keeps back-to-back bursts bubble-free.
        if (load) begin
            cur_id_d   = head.id;
            cur_err_d  = head.err;
            beat_cnt_d = head.len;
        end
    end

    assign pop = load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            cur_id_q   <= '0;
            cur_err_q  <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            cur_id_q   <= cur_id_d;
            cur_err_q  <= cur_err_d;
            size_err_q <= size_err_d;
        end
    end

endmodule

// File: tb/tb_cl_pcis_rd_resp.sv
// Randomized directed bench for cl_pcis_rd_resp against a transaction-level reference model.
module tb_cl_pcis_rd_resp;

    localparam int AR_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic         arvalid;
    logic         arready;
    logic [511:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [5:0]   rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [2:0]   ar_outstanding;
    logic         size_err;

    always #5 clk = ~clk;

    cl_pcis_rd_resp #(
        .ID_W(6), .LEN_W(8), .DATA_W(512), .AR_DEPTH(AR_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ar_outstanding(ar_outstanding), .size_err(size_err)
    );

    typedef struct { logic [5:0] id; logic [7:0] len; logic [2:0] size; } req_t;
    typedef struct { logic [5:0] id; int beats; bit err; } pend_t;

    int checks = 0;
    int failures = 0;

    // Reference model: requests waiting, the burst in progress, and upstream data order.
    req_t         ar_src[$];
    pend_t        m_pend[$];
    logic [511:0] stream_q[$];
    bit           m_in_burst = 0;
    logic [5:0]   m_id = '0;
    bit           m_err = 0;
    int           m_rem = 0;
    bit           m_size_err = 0;

    int p_ar = 100, p_tv = 100, p_rr = 100;
    bit st_en = 1;
    int cyc = 0, beats = 0, lasts = 0, first_beat = -1, last_beat = -1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic issue(input logic [5:0] id, input logic [7:0] len, input logic [2:0] size);
        req_t r;
        r.id = id; r.len = len; r.size = size;
        ar_src.push_back(r);
        for (int i = 0; i <= int'(len); i++) stream_q.push_back(rnd512());
    endtask

    task automatic check_now();
        chk("arready", arready, m_pend.size() < AR_DEPTH);
        chk("ar_outstanding", ar_outstanding, m_pend.size());
        chk("rvalid", rvalid, m_in_burst && s_tvalid);
        chk("s_tready", s_tready, m_in_burst && rready);
        chk("size_err", size_err, m_size_err);
        if (m_in_burst) begin
            chk("rid", rid, m_id);
            chk("rresp", rresp, m_err ? 2'b10 : 2'b00);
            chk("rlast", rlast, m_rem == 1);
            if (s_tvalid && stream_q.size() > 0) chk("rdata", rdata, stream_q[0]);
        end else begin
            chk("rlast_idle", rlast, 1'b0);
        end
    endtask

    task automatic start_next();
        pend_t e;
        e = m_pend.pop_front();
        m_id = e.id; m_err = e.err; m_rem = e.beats; m_in_burst = 1;
    endtask

    // One clock: check mid-cycle, advance the model at the edge, then drive new inputs.
    task automatic step();
        bit    beat, ar_hs;
        pend_t p;
        #4;
        check_now();
        beat  = m_in_burst && s_tvalid && rready;
        ar_hs = arvalid && (m_pend.size() < AR_DEPTH);
        @(posedge clk);
        cyc++;
        if (beat) begin
            beats++;
            if (m_rem == 1) lasts++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            void'(stream_q.pop_front());
        end
        if (!m_in_burst) begin
            if (m_pend.size() > 0) start_next();
        end else if (beat) begin
            if (m_rem > 1)               m_rem--;
            else if (m_pend.size() > 0)  start_next();
            else                         m_in_burst = 0;
        end
        if (ar_hs) begin
            p.id = ar_src[0].id; p.beats = int'(ar_src[0].len) + 1; p.err = (ar_src[0].size != 3'b110);
            m_pend.push_back(p);
            if (p.err) m_size_err = 1;
            void'(ar_src.pop_front());
        end
        #1;
        if (ar_hs) arvalid = 1'b0;
        if (!arvalid && ar_src.size() > 0 && pct(p_ar)) begin
            arvalid = 1'b1; arid = ar_src[0].id; arlen = ar_src[0].len; arsize = ar_src[0].size;
        end
        if (beat) s_tvalid = 1'b0;
        if (!s_tvalid && st_en && stream_q.size() > 0 && pct(p_tv)) begin
            s_tvalid = 1'b1; s_tdata = stream_q[0];
        end
        rready = pct(p_rr);
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n = 0;
        while (!(m_pend.size() == 0 && !m_in_burst && ar_src.size() == 0 && !arvalid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            failures++;
            $error("FAIL %s_timeout observed=%0d expected<%0d", tag, n, budget);
        end
        step();
    endtask

    task automatic new_phase();
        beats = 0; lasts = 0; first_beat = -1; last_beat = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arready"}, arready, 1'b1);
        chk({tag, "_s_tready"}, s_tready, 1'b0);
        chk({tag, "_rvalid"}, rvalid, 1'b0);
        chk({tag, "_rlast"}, rlast, 1'b0);
        chk({tag, "_rid"}, rid, 6'd0);
        chk({tag, "_rresp"}, rresp, 2'b00);
        chk({tag, "_ar_outstanding"}, ar_outstanding, 3'd0);
        chk({tag, "_size_err"}, size_err, 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; arvalid = 1'b0; arid = '0; arlen = '0; arsize = '0;
        s_tvalid = 1'b0; s_tdata = '0; rready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rready = 1'b1;

        // Single 4-beat burst, then a 256-beat burst.
        new_phase(); issue(6'd5, 8'd3, 3'b110); run_idle("len3", 50);
        chk("len3_beats", beats, 4); chk("len3_lasts", lasts, 1);
        new_phase(); issue(6'd5, 8'd255, 3'b110); run_idle("len255", 400);
        chk("len255_beats", beats, 256); chk("len255_lasts", lasts, 1);

        // Back-to-back bursts with no idle cycle between them.
        new_phase(); issue(6'd1, 8'd0, 3'b110); issue(6'd2, 8'd1, 3'b110); run_idle("b2b", 50);
        chk("b2b_beats", beats, 3); chk("b2b_lasts", lasts, 2);
        chk("b2b_span", last_beat - first_beat, 2);

        // rready held low mid-burst.
        new_phase(); issue(6'd7, 8'd7, 3'b110);
        n = 0;
        while (beats < 2 && n < 50) begin step(); n++; end
        p_rr = 0;
        repeat (5) step();
        p_rr = 100;
        run_idle("stall", 50);
        chk("stall_beats", beats, 8); chk("stall_lasts", lasts, 1);

        // Queue fill with no stream data, then drain including push/pop at full.
        new_phase(); st_en = 0;
        for (int i = 0; i < 6; i++) issue(6'(10 + i), 8'd1, 3'b110);
        repeat (12) step();
        chk("full_outstanding", ar_outstanding, 3'd4);
        chk("full_arready", arready, 1'b0);
        st_en = 1;
        run_idle("fill", 100);
        chk("fill_beats", beats, 12); chk("fill_lasts", lasts, 6);

        // Size error request followed by a good one.
        new_phase(); issue(6'd3, 8'd1, 3'b011); issue(6'd4, 8'd0, 3'b110); run_idle("serr", 50);
        chk("serr_sticky", size_err, 1'b1); chk("serr_beats", beats, 3);

        // Randomized traffic with random handshakes.
        new_phase(); p_ar = 60; p_tv = 70; p_rr = 70;
        for (int i = 0; i < 25; i++)
            issue(6'($urandom), pct(15) ? 8'($urandom_range(40)) : 8'($urandom_range(7)),
                  pct(80) ? 3'b110 : 3'($urandom_range(5)));
        run_idle("random", 6000);
        chk("random_empty", ar_outstanding, 3'd0);

        // Asynchronous reset in the middle of a 4-beat burst.
        p_ar = 100; p_tv = 100; p_rr = 100;
        new_phase(); issue(6'd9, 8'd3, 3'b110);
        n = 0;
        while (!(m_in_burst && beats >= 1 && m_rem >= 2) && n < 30) begin step(); n++; end
        chk("midburst_reached", m_in_burst && m_rem >= 2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        arvalid = 1'b0; s_tvalid = 1'b0;
        ar_src.delete(); stream_q.delete(); m_pend.delete();
        m_in_burst = 0; m_size_err = 0;
        @(posedge clk); #3;
        check_reset_outputs("held_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        new_phase(); issue(6'd11, 8'd2, 3'b110); run_idle("post_reset", 50);
        chk("post_reset_beats", beats, 3); chk("post_reset_lasts", lasts, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
